// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-interlock bundle for hazard_unit_mc.
// stall_cycles exists only when HAZ_STATS_EN is defined.
interface hazard_unit_mc_if #(
    parameter int unsigned REG_AW = 5
);
    logic              mem_rd_e;
    logic [REG_AW-1:0] rt_e;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic              use_rs_i;
    logic              use_rt_i;
    logic              md_start_e;
    logic              md_use_i;
    logic              flush;
    logic              pc_ifd_wr;
    logic              md_busy;
`ifdef HAZ_STATS_EN
    logic [31:0]       stall_cycles;

    modport master (
        output mem_rd_e, rt_e, rs_i, rt_i, use_rs_i, use_rt_i, md_start_e, md_use_i,
        input  flush, pc_ifd_wr, md_busy, stall_cycles
    );
    modport slave (
        input  mem_rd_e, rt_e, rs_i, rt_i, use_rs_i, use_rt_i, md_start_e, md_use_i,
        output flush, pc_ifd_wr, md_busy, stall_cycles
    );
`else
    modport master (
        output mem_rd_e, rt_e, rs_i, rt_i, use_rs_i, use_rt_i, md_start_e, md_use_i,
        input  flush, pc_ifd_wr, md_busy
    );
    modport slave (
        input  mem_rd_e, rt_e, rs_i, rt_i, use_rs_i, use_rt_i, md_start_e, md_use_i,
        output flush, pc_ifd_wr, md_busy
    );
`endif
endinterface

// File: rtl/hazard_unit_mc.sv
// Load-use and MUL/DIV pipeline interlock with parametrised load and MUL/DIV latency.
// Optional macro HAZ_STATS_EN adds a saturating stall-cycle counter (bus.stall_cycles).
module hazard_unit_mc #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MD_LAT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    hazard_unit_mc_if.slave bus
);
    localparam int unsigned LD_W = $clog2(LOAD_LAT + 1);
    localparam int unsigned MD_W = $clog2(MD_LAT + 1);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            ld_busy;
    logic            md_busy_w;
    logic            src_match;
    logic            ld_hit;
    logic            stall;

    // Hazard detection and counter next-state; a hit costs LOAD_LAT cycles including this one.
    always_comb begin
        ld_busy   = (ld_cnt_q != '0);
        md_busy_w = (md_cnt_q != '0);
        src_match = (bus.use_rs_i && (bus.rs_i == bus.rt_e)) ||
                    (bus.use_rt_i && (bus.rt_i == bus.rt_e));
        ld_hit    = bus.mem_rd_e && (bus.rt_e != ZERO_REG) && src_match && !ld_busy;
        stall     = !rst && (ld_hit || ld_busy || (bus.md_use_i && md_busy_w));

        ld_cnt_d = ld_cnt_q;
        if (ld_hit) begin
            ld_cnt_d = LD_W'(LOAD_LAT - 1);
        end else if (ld_busy) begin
            ld_cnt_d = ld_cnt_q - LD_W'(1);
        end

        md_cnt_d = md_cnt_q;
        if (bus.md_start_e) begin
            md_cnt_d = MD_W'(MD_LAT);
        end else if (md_busy_w) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Outputs react in the same cycle as the hazard so the bubble lands on the right instruction.
    assign bus.flush     = stall;
    assign bus.pc_ifd_wr = !stall;
    assign bus.md_busy   = !rst && md_busy_w;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus;
// directed table, a stall-statistics sequence, then random cycles against a timeline model.
module tb_hazard_unit_mc;
    localparam int unsigned AW  = 5;
    localparam int unsigned MDL = 4;
    localparam int unsigned LA  = 1;
    localparam int unsigned LB  = 3;

    typedef struct packed {
        logic          rst;
        logic          mem_rd;
        logic [AW-1:0] rt_e;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
        logic          md_start;
        logic          md_use;
        logic          fa;
        logic          fb;
        logic          busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(AW)) if_a ();
    hazard_unit_mc_if #(.REG_AW(AW)) if_b ();

    hazard_unit_mc #(.REG_AW(AW), .LOAD_LAT(LA), .MD_LAT(MDL)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    hazard_unit_mc #(.REG_AW(AW), .LOAD_LAT(LB), .MD_LAT(MDL)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: absolute cycle numbers of the last load-stall cycle and of the last MUL/DIV issue.
    int     lat[2]      = '{LA, LB};
    int     ld_until[2] = '{-1, -1};
    int     md_at[2]    = '{0, 0};
    bit     md_v[2]     = '{1'b0, 1'b0};
    longint st_cnt[2]   = '{0, 0};

    function automatic vec_t mk(input bit r, input bit m, input int te, input int s, input int t,
                                input bit urs, input bit urt, input bit ms, input bit mu,
                                input bit fa, input bit fb, input bit bz);
        vec_t v;
        v.rst = r; v.mem_rd = m;
        v.rt_e = AW'(te); v.rs = AW'(s); v.rt = AW'(t);
        v.use_rs = urs; v.use_rt = urt; v.md_start = ms; v.md_use = mu;
        v.fa = fa; v.fb = fb; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        if_a.mem_rd_e = v.mem_rd;   if_b.mem_rd_e = v.mem_rd;
        if_a.rt_e = v.rt_e;         if_b.rt_e = v.rt_e;
        if_a.rs_i = v.rs;           if_b.rs_i = v.rs;
        if_a.rt_i = v.rt;           if_b.rt_i = v.rt;
        if_a.use_rs_i = v.use_rs;   if_b.use_rs_i = v.use_rs;
        if_a.use_rt_i = v.use_rt;   if_b.use_rt_i = v.use_rt;
        if_a.md_start_e = v.md_start; if_b.md_start_e = v.md_start;
        if_a.md_use_i = v.md_use;   if_b.md_use_i = v.md_use;
    endtask

    function automatic void model_eval(input int k, input vec_t v,
                                       output bit f, output bit b, output bit h);
        bit in_ld;
        f = 1'b0; b = 1'b0; h = 1'b0;
        if (!v.rst) begin
            in_ld = (cyc <= ld_until[k]);
            b = md_v[k] && (cyc > md_at[k]) && (cyc <= md_at[k] + int'(MDL));
            h = !in_ld && v.mem_rd && (v.rt_e != 0) &&
                ((v.use_rs && v.rs == v.rt_e) || (v.use_rt && v.rt == v.rt_e));
            f = h || in_ld || (v.md_use && b);
        end
    endfunction

    // One clock cycle: apply, compare before the edge, advance the model at the edge.
    task automatic step(input vec_t v, input bit use_tbl);
        bit f[2], b[2], h[2];
        drive(v);
        for (int k = 0; k < 2; k++) model_eval(k, v, f[k], b[k], h[k]);
        #1;
        if (use_tbl) begin
            check("flush_a", if_a.flush, v.fa);
            check("pc_ifd_wr_a", if_a.pc_ifd_wr, !v.fa);
            check("flush_b", if_b.flush, v.fb);
            check("pc_ifd_wr_b", if_b.pc_ifd_wr, !v.fb);
            check("md_busy_a", if_a.md_busy, v.busy);
            check("md_busy_b", if_b.md_busy, v.busy);
        end else begin
            check("rnd_flush_a", if_a.flush, f[0]);
            check("rnd_pc_ifd_wr_a", if_a.pc_ifd_wr, !f[0]);
            check("rnd_flush_b", if_b.flush, f[1]);
            check("rnd_pc_ifd_wr_b", if_b.pc_ifd_wr, !f[1]);
            check("rnd_md_busy_a", if_a.md_busy, b[0]);
            check("rnd_md_busy_b", if_b.md_busy, b[1]);
`ifdef HAZ_STATS_EN
            check32("rnd_stall_cycles_a", if_a.stall_cycles, 32'(st_cnt[0]));
            check32("rnd_stall_cycles_b", if_b.stall_cycles, 32'(st_cnt[1]));
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (v.rst) begin
                ld_until[k] = -1;
                md_v[k] = 1'b0;
                st_cnt[k] = 0;
            end else begin
                if (h[k]) ld_until[k] = cyc + lat[k] - 1;
                if (v.md_start) begin
                    md_at[k] = cyc;
                    md_v[k] = 1'b1;
                end
                if (f[k] && st_cnt[k] < 64'hFFFF_FFFF) st_cnt[k]++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    vec_t tbl[$];
    vec_t idle;
    vec_t rv;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //                 r m te s t urs urt ms mu   fa fb bz
        tbl.push_back(mk(1, 1, 8, 8, 0, 1, 0, 0, 1,   0, 0, 0)); // reset masks a hit
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0,   1, 1, 0)); // rs load-use hit
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0,   1, 1, 0)); // hit held: no re-detect in B
        tbl.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0,   1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0)); // register 0
        tbl.push_back(mk(0, 1, 5, 3, 5, 1, 0, 0, 0,   0, 0, 0)); // rt match but unused
        tbl.push_back(mk(0, 0, 5, 5, 0, 1, 0, 0, 0,   0, 0, 0)); // not a load
        tbl.push_back(mk(0, 1, 9, 0, 9, 0, 1, 0, 0,   1, 1, 0)); // rt load-use hit
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0)); // MUL/DIV issue
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0)); // busy without use, restart
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0)); // overlap load + md
        tbl.push_back(mk(0, 1, 4, 4, 0, 1, 0, 0, 1,   1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 4, 0, 1, 0, 1, 0,   1, 1, 0)); // reset mid-stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));

        drive(tbl[0]);
        @(negedge clk);
        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Load stall then MUL/DIV stall back to back: 1+4 stalls in A, 3+4 in B.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        step(mk(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) step(idle, 1'b0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
        step(idle, 1'b0);
`ifdef HAZ_STATS_EN
        check32("stats_a", if_a.stall_cycles, 32'd5);
        check32("stats_b", if_b.stall_cycles, 32'd7);
`endif
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`ifdef HAZ_STATS_EN
        check32("stats_a_rst", if_a.stall_cycles, 32'd0);
        check32("stats_b_rst", if_b.stall_cycles, 32'd0);
`endif

        // Random traffic over a small register range so hits are frequent.
        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom % 64) == 0, $urandom % 2,
                    int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                    $urandom % 2, $urandom % 2, ($urandom % 6) == 0, $urandom % 2,
                    0, 0, 0);
            step(rv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
